// File: rtl/feaddsub.sv
// Word-serial modular add/sub over p = 2^(N*W) - C. Each limb produces a raw
// result and a p-corrected result in parallel; the final carries choose the
// canonical one. Optional negate (op=2'b10) is enabled by FEADDSUB_NEG_EN.
module feaddsub #(
  parameter int W    = 17,
  parameter int N    = 15,
  parameter int C    = 19,
  parameter int LOGN = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] out
);
  localparam int L = N*W;
  localparam logic [W-1:0] CW = C[W-1:0];
  // Limb 0 of p is 2^W - C; every higher limb is all ones.
  localparam logic [W-1:0] P0 = -CW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] i_q, i_d;
  logic [L-1:0]    a_q, a_d, b_q, b_d;
  logic [L-1:0]    raw_q, raw_d, cor_q, cor_d, out_q, out_d;
  logic            sub_q, sub_d, c0_q, c0_d, c1_q, c1_d, done_q, done_d;
  logic [W-1:0]    pi;
  logic [W:0]      r, t;
  logic            sel_cor;

  // Limb datapath: r is a+-b, t is r corrected by -+p; both carry chains run in lockstep.
  always_comb begin
    pi = (i_q == '0) ? P0 : '1;
    if (sub_q) begin
      r       = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, c0_q};
      t       = {1'b0, r[W-1:0]} + {1'b0, pi} + {{W{1'b0}}, c1_q};
      sel_cor = r[W];
    end else begin
      r       = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, c0_q};
      t       = {1'b0, r[W-1:0]} - {1'b0, pi} - {{W{1'b0}}, c1_q};
      sel_cor = !(!r[W] && t[W]);
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    raw_d   = raw_q;
    cor_d   = cor_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          sub_d = op[0];
`ifdef FEADDSUB_NEG_EN
          if (op == 2'b10) begin
            a_d   = '0;
            b_d   = a_in;
            sub_d = 1'b1;
          end
`endif
          i_d     = '0;
          c0_d    = 1'b0;
          c1_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> W;
        b_d   = b_q >> W;
        raw_d = {r[W-1:0], raw_q[L-1:W]};
        cor_d = {t[W-1:0], cor_q[L-1:W]};
        c0_d  = r[W];
        c1_d  = t[W];
        i_d   = i_q + 1'b1;
        if (i_q == LOGN'(N-1)) begin
          out_d   = sel_cor ? cor_d : raw_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef FEADDSUB_NEG_EN
  logic unused_op1;
  assign unused_op1 = op[1];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      raw_q   <= '0;
      cor_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      raw_q   <= raw_d;
      cor_q   <= cor_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign out  = out_q;
endmodule
